// File: rtl/divs_restoring_seq.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor, radix-2 restoring on magnitudes.
// Optional DIV_OVF_SAT_EN adds an ovf port and saturates overflowing / divide-by-zero quotients.
module divs_restoring_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder
`ifdef DIV_OVF_SAT_EN
  ,
  output logic           ovf
`endif
);

  localparam int CW = $clog2(2*W+1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [2*W-1:0] acc_reg;      // dividend magnitude shifting out, quotient bits shifting in
  logic [W-1:0]   rem_reg;
  logic [W-1:0]   div_mag_reg;
  logic [W-1:0]   dvd_low_reg;
  logic [CW-1:0]  cnt_reg;
  logic           neg_q_reg;
  logic           neg_r_reg;
  logic           zero_reg;

  logic [2*W-1:0] dvd_mag;
  logic [W-1:0]   dsr_mag;
  logic [W:0]     trial;
  logic           ge;
  logic [W-1:0]   rem_step;
  logic [W-1:0]   q_wrap;
  logic [W-1:0]   r_signed;
  logic [W-1:0]   q_final;

  assign dvd_mag  = dividend[2*W-1] ? -dividend : dividend;
  assign dsr_mag  = divisor[W-1] ? -divisor : divisor;

  // Partial remainder stays below |divisor| <= 2^(W-1), so W+1 bits hold the trial value.
  assign trial    = {rem_reg, acc_reg[2*W-1]};
  assign ge       = trial >= {1'b0, div_mag_reg};
  assign rem_step = ge ? W'(trial - {1'b0, div_mag_reg}) : trial[W-1:0];

  assign q_wrap   = neg_q_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
  assign r_signed = neg_r_reg ? -rem_reg : rem_reg;

`ifdef DIV_OVF_SAT_EN
  localparam logic [2*W-1:0] POS_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] NEG_MAG = POS_MAX + {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   Q_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   Q_MIN   = {1'b1, {(W-1){1'b0}}};

  logic ovf_final;

  always_comb begin
    ovf_final = 1'b1;
    q_final   = q_wrap;
    if (zero_reg) begin
      q_final = neg_r_reg ? Q_MIN : Q_MAX;
    end else begin
      ovf_final = neg_q_reg ? (acc_reg > NEG_MAG) : (acc_reg > POS_MAX);
      if (ovf_final)
        q_final = neg_q_reg ? Q_MIN : Q_MAX;
    end
  end
`else
  assign q_final = zero_reg ? {W{1'b1}} : q_wrap;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      acc_reg     <= '0;
      rem_reg     <= '0;
      div_mag_reg <= '0;
      dvd_low_reg <= '0;
      cnt_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      zero_reg    <= 1'b0;
`ifdef DIV_OVF_SAT_EN
      ovf         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc_reg     <= dvd_mag;
            rem_reg     <= '0;
            div_mag_reg <= dsr_mag;
            dvd_low_reg <= dividend[W-1:0];
            neg_q_reg   <= dividend[2*W-1] ^ divisor[W-1];
            neg_r_reg   <= dividend[2*W-1];
            zero_reg    <= (divisor == '0);
            // A zero divisor skips the iterations and finalises on the next cycle.
            cnt_reg     <= (divisor == '0) ? '0 : CW'(2*W);
            in_ready    <= 1'b0;
            state       <= CALC;
          end
        end
        CALC: begin
          if (cnt_reg != '0) begin
            acc_reg <= {acc_reg[2*W-2:0], ge};
            rem_reg <= rem_step;
            cnt_reg <= cnt_reg - CW'(1);
          end else begin
            quotient  <= q_final;
            remainder <= zero_reg ? dvd_low_reg : r_signed;
`ifdef DIV_OVF_SAT_EN
            ovf       <= ovf_final;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef DIV_OVF_SAT_EN
            ovf       <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divs_restoring_seq.sv
// Directed vector bench for divs_restoring_seq at W=4; expectations follow DIV_OVF_SAT_EN when defined.
module tb_divs_restoring_seq;

  localparam int W = 4;
`ifdef DIV_OVF_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   dividend = '0;
  logic [3:0]   divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [3:0]   quotient;
  logic [3:0]   remainder;
`ifdef DIV_OVF_SAT_EN
  logic         ovf;
`endif

  divs_restoring_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
`ifdef DIV_OVF_SAT_EN
    .ovf       (ovf),
`endif
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dsr;
    logic [3:0] q;
    logic [3:0] r;
    logic       ov;
    int         lat;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands at a negedge once in_ready is high; scramble them right after the accept edge.
  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  // Counts clock edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_vec(input vec_t v, input int idx);
    int lat;
    start_op(v.dvd, v.dsr);
    wait_result(lat);
    chk("latency", 32'(lat), 32'(v.lat));
    chk("quotient", 32'(quotient), 32'(v.q));
    chk("remainder", 32'(remainder), 32'(v.r));
`ifdef DIV_OVF_SAT_EN
    chk("ovf", 32'(ovf), 32'(v.ov));
`endif
    chk("in_ready_in_done", 32'(in_ready), 32'd0);
    $display("vec %0d: %0d / %0d -> q=0x%0h r=0x%0h lat=%0d", idx, $signed(v.dvd), $signed(v.dsr),
             quotient, remainder, lat);
    @(negedge clk);
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t vecs [13];
    vec_t v72;
    int   lat;

    vecs[0]  = '{8'd23,  4'd5,  4'h4, 4'h3, 1'b0, 9};
    vecs[1]  = '{8'hE9,  4'd5,  4'hC, 4'hD, 1'b0, 9};
    vecs[2]  = '{8'd23,  4'hB,  4'hC, 4'h3, 1'b0, 9};
    vecs[3]  = '{8'hE9,  4'hB,  4'h4, 4'hD, 1'b0, 9};
    vecs[4]  = '{8'hF0,  4'd2,  4'h8, 4'h0, 1'b0, 9};
    vecs[5]  = '{8'h17,  4'd0,  SAT ? 4'h7 : 4'hF, 4'h7, 1'b1, 1};
    vecs[6]  = '{8'hFD,  4'd0,  SAT ? 4'h8 : 4'hF, 4'hD, 1'b1, 1};
    vecs[7]  = '{8'd100, 4'd3,  SAT ? 4'h7 : 4'h1, 4'h1, 1'b1, 9};
    vecs[8]  = '{8'h80,  4'hF,  SAT ? 4'h7 : 4'h0, 4'h0, 1'b1, 9};
    vecs[9]  = '{8'h80,  4'h1,  SAT ? 4'h8 : 4'h0, 4'h0, 1'b1, 9};
    vecs[10] = '{8'h7F,  4'h8,  SAT ? 4'h8 : 4'h1, 4'h7, 1'b1, 9};
    vecs[11] = '{8'hF8,  4'd3,  4'hE, 4'hE, 1'b0, 9};
    vecs[12] = '{8'd5,   4'd7,  4'h0, 4'h5, 1'b0, 9};
    v72      = '{8'd7,   4'd2,  4'h3, 4'h1, 1'b0, 9};

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
`ifdef DIV_OVF_SAT_EN
    chk("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      do_vec(vecs[i], i);

    // Backpressure: result held for 5 cycles, a stray in_valid pulse must be ignored.
    out_ready = 1'b0;
    start_op(8'd23, 4'd5);
    wait_result(lat);
    chk("bp_latency", 32'(lat), 32'd9);
    for (int i = 0; i < 5; i++) begin
      chk("bp_quotient", 32'(quotient), 32'h4);
      chk("bp_remainder", 32'(remainder), 32'h3);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      if (i == 1) begin
        in_valid = 1'b1;
        dividend = 8'h17;
        divisor  = 4'h0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    $display("backpressure: held 5 cycles, released");
    do_vec(v72, 100);

    // Reset while CALC performs its third step.
    start_op(8'd23, 4'd5);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (11) @(negedge clk);
    chk("abort_no_output", 32'(out_valid), 32'd0);
    $display("reset mid-op: aborted at CALC step 3");
    do_vec(v72, 101);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/divs_restoring_seq.md
Name: divs_restoring_seq

Overview:
- Sequential signed divider; the inverse of the registered signed multiplier wrappers in the multiplier sweep.
- Takes a 2W-bit product-width dividend and a W-bit divisor, and returns a W-bit quotient and a W-bit remainder.
- Radix-2 restoring iteration on magnitudes, with valid/ready handshakes on both sides and one operation in flight.
- Used as the divide-side counterpart in the same PPA sweep flow, with default W=4 matching the 4x4 -> 8 multiplier.

Parameters:
W, 4, operand width; dividend is 2W bits, divisor/quotient/remainder are W bits; legal range 2..32

Ports:
clk  input  1  clock; all logic on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
in_valid  input  1  operand valid
in_ready  output  1  block can accept operands
dividend  input  2W  signed two's-complement dividend
divisor  input  W  signed two's-complement divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  W  signed quotient, registered
remainder  output  W  signed remainder, registered
ovf  output  1  overflow/div-by-zero flag; present only with DIV_OVF_SAT_EN

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, ovf=0.
  - Reset mid-operation aborts the operation with no output.
- States:
  - IDLE: in_ready=1. in_valid&&in_ready captures the operands, sign bits and magnitudes.
    - If divisor==0 -> DONE next cycle.
    - Otherwise -> CALC with iteration counter = 2W.
  - CALC: one restoring step per cycle on 2W-bit |dividend| and W-bit |divisor|:
    - Shift the partial remainder left by 1 and bring in the next dividend bit.
    - Trial-subtract |divisor|; keep the difference if it is non-negative, else restore.
    - Shift the quotient bit into a 2W-bit quotient register.
    - After the 2W-th step -> DONE.
  - DONE: out_valid=1; quotient/remainder are stable until out_valid&&out_ready, then -> IDLE. in_ready=0 in CALC and DONE.
- Latency, from the accept edge to out_valid high:
  - normal: 2W+1 cycles (9 for W=4)
  - divisor==0: 1 cycle
- Throughput:
  - In DONE, in_ready stays low even if out_ready=1, so there is a minimum 1 idle cycle between results.
  - in_valid while not ready is ignored; operands are not required stable after the accept.
- Sign and width rules:
  - Quotient truncates toward zero. Remainder takes the sign of the dividend; |remainder| < |divisor|.
  - Final quotient is negated if the operand signs differ; the remainder is negated if the dividend is negative.
  - Output quotient = low W bits of the exact 2W-bit signed quotient (wraps on overflow).
  - Remainder always fits W bits.
  - Most-negative dividend (-2^(2W-1)) is handled; its magnitude fits 2W unsigned bits.
- Divide by zero: quotient = all ones, remainder = dividend[W-1:0].
- No X propagation: quotient/remainder hold their last value outside DONE.

Optional Feature:
DIV_OVF_SAT_EN
- Defined:
  - The ovf port exists, registered, valid with out_valid, and 0 otherwise.
  - ovf=1 if the exact quotient lies outside [-2^(W-1), 2^(W-1)-1] or divisor==0.
  - On overflow, the quotient saturates to 2^(W-1)-1 (positive exact) or -2^(W-1) (negative exact); the remainder is still the true remainder.
  - Divide by zero gives quotient = 2^(W-1)-1 for dividend>=0 and -2^(W-1) for dividend<0; remainder = dividend[W-1:0].
  - Latency is unchanged.
- Undefined: no ovf port; wrap and all-ones behaviour as in Behaviour.

Test Plan:
- W=4, dividend=23, divisor=5, out_ready=1 -> out_valid exactly 9 cycles after accept; quotient=4, remainder=3; then in_ready=1.
- Signs: -23/5 -> q=0xC (-4), r=0xD (-3); 23/-5 -> q=-4, r=3; -23/-5 -> q=4, r=-3; -16/2 -> q=0x8 (-8), r=0, ovf=0.
- Divide by zero: 0x17/0 -> out_valid 1 cycle after accept.
  - Macro undefined: q=0xF, r=0x7.
  - Macro defined: q=0x7, r=0x7, ovf=1.
  - Same with dividend=-3: macro undefined q=0xF; macro defined q=0x8.
- Overflow: 100/3 -> r=1; macro undefined q=0x1; macro defined q=0x7, ovf=1. -128/-1 -> r=0; macro undefined q=0x0; macro defined q=0x7, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Outputs stay stable and in_ready=0; an in_valid pulse during this window is not accepted.
  - out_ready=1 -> IDLE next cycle; the next operation then accepts and completes correctly.
- Reset mid-op: assert rst_n=0 for 1 cycle at CALC step 3 -> out_valid=0, q=r=0, in_ready=1 after reset; a following 7/2 gives q=3, r=1.
